encoder_scanner: RTL



---
 rtl/encoder_pkg.sv | 15 +
 rtl/encoder_step.sv | 45 ++++
 rtl/encoder_scanner.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared types for the time-multiplexed quadrature encoder scanner.
package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    READY   = 2'd2,
    CONFIRM = 2'd3
  } dec_state_t;

  localparam logic [1:0] DIR_UP  = 2'b10;
  localparam logic [1:0] DIR_DN  = 2'b01;
  localparam logic [1:0] XY_REST = 2'b11;

endpackage

// File: rtl/encoder_step.sv
// Combinational quadrature step rule for one channel: next state, next direction, count delta.
// Zero latency; no flow control, evaluated for whichever channel the scanner presents.
module encoder_step
  import encoder_pkg::*;
(
  input  dec_state_t        st,
  input  logic [1:0]        dir,
  input  logic [1:0]        xy,
  output dec_state_t        st_nxt,
  output logic [1:0]        dir_nxt,
  output logic signed [1:0] delta
);

  always_comb begin
    st_nxt  = st;
    dir_nxt = dir;
    delta   = 2'sd0;
    case (st)
      IDLE: begin
        if (xy == XY_REST) st_nxt = ARM;
      end
      ARM: begin
        st_nxt = (xy == XY_REST) ? READY : IDLE;
      end
      READY: begin
        if (xy == DIR_UP || xy == DIR_DN) begin
          dir_nxt = xy;
          st_nxt  = CONFIRM;
        end
      end
      CONFIRM: begin
        // A second matching sample confirms the step; anything else falls back to READY.
        if (xy == dir) begin
          if (dir == DIR_UP)      delta = 2'sd1;
          else if (dir == DIR_DN) delta = -2'sd1;
          st_nxt = IDLE;
        end else begin
          st_nxt = READY;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/encoder_scanner.sv
// Shares one quadrature step engine round-robin across N_CH encoder channels.
// Reads ack one clock after rd_req; no backpressure, every in-range request is accepted.
module encoder_scanner
  import encoder_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 8,
  parameter int SCAN_DIV = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         enc_x,
  input  logic [N_CH-1:0]         enc_y,
  input  logic                    rd_req,
  input  logic [$clog2(N_CH)-1:0] rd_ch,
  output logic                    rd_ack,
  output logic [CNT_W-1:0]        rd_data,
  input  logic                    clr_req,
  input  logic [$clog2(N_CH)-1:0] clr_ch,
  output logic [N_CH-1:0]         changed,
  output logic [$clog2(N_CH)-1:0] scan_ch
);

  localparam int CH_W = $clog2(N_CH);
  localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CH_W:0]   N_CH_L  = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  localparam logic [PW-1:0]   LAST_PS = PW'(SCAN_DIV - 1);

  logic [N_CH-1:0] x_meta, x_sync, y_meta, y_sync;
  logic [PW-1:0]   presc;
  logic            tick;

  dec_state_t       st_q  [N_CH];
  logic [1:0]       dir_q [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];

  dec_state_t        st_nxt;
  logic [1:0]        dir_nxt;
  logic signed [1:0] delta;
  logic [1:0]        xy;
  logic [CNT_W-1:0]  cnt_cur, cnt_nxt;

  logic            rd_ok, clr_ok;
  logic [N_CH-1:0] scan_hit, clr_hit, rd_hit, step_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_meta <= '0;
      x_sync <= '0;
      y_meta <= '0;
      y_sync <= '0;
    end else begin
      x_meta <= enc_x;
      x_sync <= x_meta;
      y_meta <= enc_y;
      y_sync <= y_meta;
    end
  end

  assign tick = (presc == LAST_PS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      scan_ch <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) scan_ch <= (scan_ch == LAST_CH) ? '0 : scan_ch + 1'b1;
    end
  end

  assign xy      = {x_sync[scan_ch], y_sync[scan_ch]};
  assign cnt_cur = cnt_q[scan_ch];

  encoder_step u_step (
    .st      (st_q[scan_ch]),
    .dir     (dir_q[scan_ch]),
    .xy      (xy),
    .st_nxt  (st_nxt),
    .dir_nxt (dir_nxt),
    .delta   (delta)
  );

  always_comb begin
    cnt_nxt = cnt_cur;
    if (delta == 2'sd1)       cnt_nxt = cnt_cur + 1'b1;
    else if (delta == -2'sd1) cnt_nxt = cnt_cur - 1'b1;
  end

  assign rd_ok  = rd_req  && ({1'b0, rd_ch}  < N_CH_L);
  assign clr_ok = clr_req && ({1'b0, clr_ch} < N_CH_L);

  // A clear on the scanned channel discards that visit's update, including its change flag.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      scan_hit[i] = tick && (scan_ch == CH_W'(i));
      clr_hit[i]  = clr_ok && (clr_ch == CH_W'(i));
      rd_hit[i]   = rd_ok && (rd_ch == CH_W'(i));
      step_set[i] = scan_hit[i] && !clr_hit[i] && (delta != 2'sd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= IDLE;
        dir_q[i] <= 2'b00;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clr_hit[i]) begin
          st_q[i]  <= IDLE;
          dir_q[i] <= 2'b00;
          cnt_q[i] <= '0;
        end else if (scan_hit[i]) begin
          st_q[i]  <= st_nxt;
          dir_q[i] <= dir_nxt;
          cnt_q[i] <= cnt_nxt;
        end
      end
    end
  end

  // A count on the same edge as a read keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      changed <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (step_set[i])    changed[i] <= 1'b1;
        else if (rd_hit[i]) changed[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_ok;
      if (rd_ok) rd_data <= cnt_q[rd_ch];
    end
  end

endmodule
